// File: rtl/gain_pkg.sv
// Shared types and the gain lookup for the receiver gain sequencer.
// Gains are in 4 dB units; the HGA contributes 5 units (20 dB) when not bypassed.
package gain_pkg;

  localparam int GAIN_MIN       = -4;
  localparam int GAIN_MAX       = 19;
  localparam int POT_FRAME_BITS = 16;
  localparam int HGA_STEPS      = 5;
  localparam int POT_CODE_STEP  = 12;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    RELAY_PRE,
    SPI_XFER,
    RELAY_POST,
    SETTLE
  } seq_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       bypass;
  } lut_entry_t;

  function automatic logic signed [5:0] clamp_gain(input logic signed [5:0] g);
    logic signed [5:0] r;
    r = g;
    if (int'(g) < GAIN_MIN) r = 6'(GAIN_MIN);
    if (int'(g) > GAIN_MAX) r = 6'(GAIN_MAX);
    return r;
  endfunction

  // Low gains bypass the HGA; the pot covers the remainder in equal code steps.
  function automatic lut_entry_t gain_lut(input logic signed [5:0] g);
    lut_entry_t e;
    int         pga;
    e.bypass = (int'(g) < HGA_STEPS);
    pga      = e.bypass ? int'(g) : int'(g) - HGA_STEPS;
    e.code   = 8'((pga - GAIN_MIN) * POT_CODE_STEP);
    return e;
  endfunction

endpackage

// File: rtl/gain_sequencer_pot_spi_tx.sv
// Write-only SPI mode-0 transmitter for the PGA digital pot.
// One frame: 16 bits MSB first, then a trailing low phase before cs_n rises.
module pot_spi_tx
  import gain_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      start,
  input  logic [POT_FRAME_BITS-1:0] data,
  output logic                      done,
  output logic                      cs_n,
  output logic                      sclk,
  output logic                      mosi
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(POT_FRAME_BITS);

  logic                      active_reg;
  logic                      high_reg;
  logic                      tail_reg;
  logic [DIV_W-1:0]          div_reg;
  logic [BIT_W-1:0]          bits_left_reg;
  logic [POT_FRAME_BITS-1:0] shift_reg;
  logic                      cs_n_reg;
  logic                      sclk_reg;
  logic                      mosi_reg;
  logic                      phase_end;

  assign phase_end = active_reg && (div_reg == DIV_W'(SCLK_DIV - 1));
  // Pulses in the last cs_n-low cycle so the caller moves on as cs_n rises.
  assign done      = phase_end && tail_reg;
  assign cs_n      = cs_n_reg;
  assign sclk      = sclk_reg;
  assign mosi      = mosi_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      active_reg    <= 1'b0;
      high_reg      <= 1'b0;
      tail_reg      <= 1'b0;
      div_reg       <= '0;
      bits_left_reg <= '0;
      shift_reg     <= '0;
      cs_n_reg      <= 1'b1;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
    end else if (!active_reg) begin
      if (start) begin
        active_reg    <= 1'b1;
        high_reg      <= 1'b0;
        tail_reg      <= 1'b0;
        div_reg       <= '0;
        bits_left_reg <= BIT_W'(POT_FRAME_BITS - 1);
        shift_reg     <= {data[POT_FRAME_BITS-2:0], 1'b0};
        cs_n_reg      <= 1'b0;
        sclk_reg      <= 1'b0;
        mosi_reg      <= data[POT_FRAME_BITS-1];
      end
    end else if (!phase_end) begin
      div_reg <= div_reg + 1'b1;
    end else begin
      div_reg <= '0;
      if (tail_reg) begin
        active_reg <= 1'b0;
        tail_reg   <= 1'b0;
        cs_n_reg   <= 1'b1;
        mosi_reg   <= 1'b0;
      end else if (!high_reg) begin
        high_reg <= 1'b1;
        sclk_reg <= 1'b1;
      end else begin
        high_reg <= 1'b0;
        sclk_reg <= 1'b0;
        if (bits_left_reg == '0) begin
          tail_reg <= 1'b1;
        end else begin
          mosi_reg      <= shift_reg[POT_FRAME_BITS-1];
          shift_reg     <= {shift_reg[POT_FRAME_BITS-2:0], 1'b0};
          bits_left_reg <= bits_left_reg - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gain_sequencer.sv
// Receiver gain sequencer: clamps a requested gain, writes the pot code and orders
// the HGA bypass switch around the write so the total gain never overshoots.
module gain_sequencer
  import gain_pkg::*;
#(
  parameter int         SCLK_DIV      = 4,
  parameter int         SETTLE_CYCLES = 1000,
  parameter logic [7:0] POT_CMD       = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic signed [5:0] gain_req_i,
  input  logic              gain_req_valid_i,
  output logic              gain_req_ready_o,
  output logic signed [5:0] gain_dB_o,
  output logic              settled_o,
  output logic              hga_bypass_o,
  output logic              pot_cs_n_o,
  output logic              pot_sclk_o,
  output logic              pot_mosi_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  seq_state_t        state_reg, state_next;
  logic signed [5:0] target_reg;
  logic signed [5:0] gain_reg;
  logic              new_bypass_reg;
  logic              bypass_reg;
  logic              settled_reg;
  logic [CNT_W-1:0]  settle_cnt_reg;

  logic signed [5:0] req_clamped;
  lut_entry_t        lut_out;
  logic              change;
  logic              spi_start;
  logic              spi_done;

  assign req_clamped = clamp_gain(gain_req_i);
  // target_reg is stable from LOOKUP through the frame, so the LUT feeds the SPI directly.
  assign lut_out     = gain_lut(target_reg);
  assign change      = (state_reg == IDLE) && gain_req_valid_i &&
                       !((req_clamped == gain_reg) && settled_reg);
  assign spi_start   = (state_next == SPI_XFER) && (state_reg != SPI_XFER);

  assign gain_req_ready_o = (state_reg == IDLE);
  assign gain_dB_o        = gain_reg;
  assign settled_o        = settled_reg;
  assign hga_bypass_o     = bypass_reg;

  pot_spi_tx #(
    .SCLK_DIV(SCLK_DIV)
  ) u_spi (
    .clk  (clk_i),
    .srst (rst_i),
    .start(spi_start),
    .data ({POT_CMD, lut_out.code}),
    .done (spi_done),
    .cs_n (pot_cs_n_o),
    .sclk (pot_sclk_o),
    .mosi (pot_mosi_o)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:       state_next = LOOKUP;
      IDLE:       if (change) state_next = LOOKUP;
      LOOKUP:     state_next = (lut_out.bypass && !bypass_reg) ? RELAY_PRE : SPI_XFER;
      RELAY_PRE:  state_next = SPI_XFER;
      SPI_XFER:   if (spi_done) state_next = (!new_bypass_reg && bypass_reg) ? RELAY_POST : SETTLE;
      RELAY_POST: state_next = SETTLE;
      SETTLE:     if (settle_cnt_reg == CNT_W'(SETTLE_CYCLES)) state_next = IDLE;
      default:    state_next = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= INIT;
      target_reg     <= '0;
      gain_reg       <= '0;
      new_bypass_reg <= 1'b1;
      bypass_reg     <= 1'b1;
      settled_reg    <= 1'b0;
      settle_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        INIT: target_reg <= '0;
        IDLE: begin
          if (change) begin
            target_reg  <= req_clamped;
            settled_reg <= 1'b0;
          end
        end
        LOOKUP: begin
          new_bypass_reg <= lut_out.bypass;
          if (state_next == RELAY_PRE) bypass_reg <= 1'b1;
        end
        RELAY_POST: bypass_reg <= 1'b0;
        SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg + 1'b1;
          if (state_next == IDLE) settled_reg <= 1'b1;
        end
        default: ;
      endcase
      if ((state_next == SETTLE) && (state_reg != SETTLE)) begin
        gain_reg       <= target_reg;
        settle_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gain_sequencer.sv
// Self-checking bench for gain_sequencer: frame monitor plus a dB-level reference model.
module tb_gain_sequencer;

  localparam int D       = 4;
  localparam int SETTLE  = 1000;
  localparam int CS_LOW  = 33 * D;
  localparam int BASE_LAT = 1 + CS_LOW + SETTLE + 1;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic signed [5:0] gain_req_i = '0;
  logic              gain_req_valid_i = 1'b0;
  logic              gain_req_ready_o;
  logic signed [5:0] gain_dB_o;
  logic              settled_o;
  logic              hga_bypass_o;
  logic              pot_cs_n_o;
  logic              pot_sclk_o;
  logic              pot_mosi_o;

  gain_sequencer #(.SCLK_DIV(D), .SETTLE_CYCLES(SETTLE), .POT_CMD(8'h00)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .gain_req_i      (gain_req_i),
    .gain_req_valid_i(gain_req_valid_i),
    .gain_req_ready_o(gain_req_ready_o),
    .gain_dB_o       (gain_dB_o),
    .settled_o       (settled_o),
    .hga_bypass_o    (hga_bypass_o),
    .pot_cs_n_o      (pot_cs_n_o),
    .pot_sclk_o      (pot_sclk_o),
    .pot_mosi_o      (pot_mosi_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: HGA adds 20 dB above 16 dB requested; the pot spans -16..+56 dB, 3 codes per dB.
  int   m_gain = 0;
  logic m_byp  = 1'b1;
  function automatic int m_clamp(input int g);
    return (g < -4) ? -4 : ((g > 19) ? 19 : g);
  endfunction
  function automatic logic m_bypass(input int g);
    return (4 * g) < 20;
  endfunction
  function automatic logic [7:0] m_code(input int g);
    int pot_db;
    pot_db = 4 * g - (m_bypass(g) ? 0 : 20);
    return 8'((pot_db + 16) * 3);
  endfunction

  // SPI / relay monitor, sampled on the falling clock edge.
  typedef struct {
    logic [15:0] data;
    int          nbits;
  } frame_t;
  frame_t      frames[$];
  logic [15:0] cur_data = '0;
  int          cur_nbits = 0;
  int          cs_fall_cnt = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
  int          byp_tog = 0, byp_rise_cyc = 0, byp_fall_cyc = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_byp = 1'b1;

  always @(negedge clk) begin
    if (pot_cs_n_o === 1'b0 && prev_cs === 1'b1) begin
      cs_fall_cyc = cyc; cs_fall_cnt++; cur_data = '0; cur_nbits = 0;
    end
    if (pot_cs_n_o === 1'b0 && pot_sclk_o === 1'b1 && prev_sclk === 1'b0) begin
      cur_data = {cur_data[14:0], pot_mosi_o}; cur_nbits++;
    end
    if (pot_cs_n_o === 1'b1 && prev_cs === 1'b0) begin
      cs_rise_cyc = cyc;
      frames.push_back('{cur_data, cur_nbits});
    end
    if (hga_bypass_o === 1'b1 && prev_byp === 1'b0) begin byp_rise_cyc = cyc; byp_tog++; end
    if (hga_bypass_o === 1'b0 && prev_byp === 1'b1) begin byp_fall_cyc = cyc; byp_tog++; end
    prev_cs = pot_cs_n_o; prev_sclk = pot_sclk_o; prev_byp = hga_bypass_o;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    total++; if (gain_dB_o !== 6'sd0) begin bad++; $display("FAIL rst_gain: got %0d want 0", gain_dB_o); end
    total++; if (settled_o !== 1'b0) begin bad++; $display("FAIL rst_settled: got %b want 0", settled_o); end
    total++; if (hga_bypass_o !== 1'b1) begin bad++; $display("FAIL rst_bypass: got %b want 1", hga_bypass_o); end
    total++; if (pot_cs_n_o !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", pot_cs_n_o); end
    total++; if (pot_sclk_o !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", pot_sclk_o); end
    total++; if (pot_mosi_o !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", pot_mosi_o); end
    total++; if (gain_req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", gain_req_ready_o); end
    $display("reset: gain=%0d settled=%b bypass=%b cs_n=%b", gain_dB_o, settled_o, hga_bypass_o, pot_cs_n_o);
  endtask

  task automatic test_init_write();
    int base, n, tog0;
    frames.delete();
    tog0 = byp_tog;
    rst_i = 1'b0;
    base = cyc;
    n = 0;
    while (settled_o !== 1'b1 && n < 3000) begin step(); n++; end
    total++; if (settled_o !== 1'b1) begin bad++; $display("FAIL init_settle_timeout: settled=%b want 1", settled_o); end
    total++; if (cyc - (base + 1) != BASE_LAT) begin bad++; $display("FAIL init_latency: got %0d want %0d", cyc - (base + 1), BASE_LAT); end
    total++; if (frames.size() != 1) begin bad++; $display("FAIL init_frames: got %0d want 1", frames.size()); end
    if (frames.size() >= 1) begin
      total++; if (frames[0].data !== {8'h00, m_code(0)} || frames[0].nbits != 16) begin
        bad++; $display("FAIL init_frame: got %h/%0d bits want %h/16", frames[0].data, frames[0].nbits, {8'h00, m_code(0)});
      end
    end
    total++; if (byp_tog != tog0 || hga_bypass_o !== 1'b1) begin bad++; $display("FAIL init_bypass: toggles=%0d bypass=%b want 0/1", byp_tog - tog0, hga_bypass_o); end
    total++; if (gain_dB_o !== 6'sd0) begin bad++; $display("FAIL init_gain: got %0d want 0", gain_dB_o); end
    m_gain = 0; m_byp = 1'b1;
    $display("init: latency=%0d frames=%0d gain=%0d", cyc - (base + 1), frames.size(), gain_dB_o);
  endtask

  task automatic test_request(input int g);
    int   exp_g, c, n, fall0, tog0, exp_lat;
    logic exp_byp, leave, enter;
    exp_g   = m_clamp(g);
    exp_byp = m_bypass(exp_g);
    leave   = exp_byp && !m_byp;
    enter   = !exp_byp && m_byp;
    n = 0;
    while (gain_req_ready_o !== 1'b1 && n < 3000) begin step(); n++; end
    total++; if (gain_req_ready_o !== 1'b1) begin bad++; $display("FAIL req_ready_wait: ready=%b want 1", gain_req_ready_o); end
    frames.delete();
    fall0 = cs_fall_cnt;
    tog0  = byp_tog;
    gain_req_i = 6'(g);
    gain_req_valid_i = 1'b1;
    c = cyc;
    step();
    gain_req_valid_i = 1'b0;
    if (exp_g == m_gain) begin
      total++; if (gain_req_ready_o !== 1'b1 || settled_o !== 1'b1) begin
        bad++; $display("FAIL repeat_status: ready=%b settled=%b want 1/1", gain_req_ready_o, settled_o);
      end
      repeat (40) step();
      total++; if (cs_fall_cnt != fall0) begin bad++; $display("FAIL repeat_frames: got %0d want 0", cs_fall_cnt - fall0); end
      total++; if (int'(gain_dB_o) != exp_g || settled_o !== 1'b1) begin
        bad++; $display("FAIL repeat_hold: gain=%0d settled=%b want %0d/1", gain_dB_o, settled_o, exp_g);
      end
      $display("req %0d: repeat of %0d, no frame", g, exp_g);
      return;
    end
    total++; if (settled_o !== 1'b0 || gain_req_ready_o !== 1'b0) begin
      bad++; $display("FAIL req_accept: settled=%b ready=%b want 0/0", settled_o, gain_req_ready_o);
    end
    n = 0;
    while (settled_o !== 1'b1 && n < 3000) begin step(); n++; end
    exp_lat = BASE_LAT + ((leave || enter) ? 1 : 0);
    total++; if (settled_o !== 1'b1) begin bad++; $display("FAIL req_settle_timeout: settled=%b want 1", settled_o); end
    total++; if (cyc - (c + 1) != exp_lat) begin bad++; $display("FAIL req_latency: got %0d want %0d", cyc - (c + 1), exp_lat); end
    total++; if (frames.size() != 1) begin bad++; $display("FAIL req_frames: got %0d want 1", frames.size()); end
    if (frames.size() >= 1) begin
      total++; if (frames[0].data !== {8'h00, m_code(exp_g)} || frames[0].nbits != 16) begin
        bad++; $display("FAIL req_frame: got %h/%0d bits want %h/16", frames[0].data, frames[0].nbits, {8'h00, m_code(exp_g)});
      end
    end
    total++; if (cs_rise_cyc - cs_fall_cyc != CS_LOW) begin bad++; $display("FAIL req_cs_low: got %0d want %0d", cs_rise_cyc - cs_fall_cyc, CS_LOW); end
    total++; if (int'(gain_dB_o) != exp_g) begin bad++; $display("FAIL req_gain: got %0d want %0d", gain_dB_o, exp_g); end
    total++; if (hga_bypass_o !== exp_byp) begin bad++; $display("FAIL req_bypass: got %b want %b", hga_bypass_o, exp_byp); end
    total++; if (byp_tog - tog0 != ((leave || enter) ? 1 : 0)) begin
      bad++; $display("FAIL req_bypass_toggles: got %0d want %0d", byp_tog - tog0, (leave || enter) ? 1 : 0);
    end
    if (leave) begin
      total++; if (cs_fall_cyc != byp_rise_cyc + 1) begin bad++; $display("FAIL relay_pre_order: cs_fall=%0d want %0d", cs_fall_cyc, byp_rise_cyc + 1); end
    end
    if (enter) begin
      total++; if (byp_fall_cyc != cs_rise_cyc + 1) begin bad++; $display("FAIL relay_post_order: bypass_fall=%0d want %0d", byp_fall_cyc, cs_rise_cyc + 1); end
    end
    m_gain = exp_g;
    m_byp  = exp_byp;
    $display("req %0d: gain=%0d bypass=%b code=%h latency=%0d", g, gain_dB_o, hga_bypass_o, m_code(exp_g), cyc - (c + 1));
  endtask

  task automatic test_gain_up();   test_request(10);  endtask
  task automatic test_gain_down(); test_request(3);   endtask
  task automatic test_clamp();     test_request(25); test_request(-10); endtask
  task automatic test_repeat();    test_request(-4); endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) test_request(int'($urandom_range(0, 63)) - 32);
  endtask

  task automatic test_reset_mid_frame();
    int t, n, base, c, fall0;
    t = (m_gain == 10) ? 2 : 10;
    n = 0;
    while (gain_req_ready_o !== 1'b1 && n < 3000) begin step(); n++; end
    frames.delete();
    gain_req_i = 6'(t);
    gain_req_valid_i = 1'b1;
    step();
    gain_req_valid_i = 1'b0;
    n = 0;
    while (!(pot_cs_n_o === 1'b0 && cur_nbits == 8) && n < 3000) begin step(); n++; end
    total++; if (cur_nbits != 8) begin bad++; $display("FAIL mid_reach_bit7: bits=%0d want 8", cur_nbits); end
    rst_i = 1'b1;
    step();
    total++; if (pot_cs_n_o !== 1'b1 || pot_sclk_o !== 1'b0) begin bad++; $display("FAIL mid_abort: cs_n=%b sclk=%b want 1/0", pot_cs_n_o, pot_sclk_o); end
    total++; if (frames.size() != 1 || frames[0].nbits != 8) begin bad++; $display("FAIL mid_partial: frames=%0d want 1 partial of 8 bits", frames.size()); end
    total++; if (gain_dB_o !== 6'sd0 || hga_bypass_o !== 1'b1 || settled_o !== 1'b0) begin
      bad++; $display("FAIL mid_rst_outputs: gain=%0d bypass=%b settled=%b want 0/1/0", gain_dB_o, hga_bypass_o, settled_o);
    end
    frames.delete();
    fall0 = cs_fall_cnt;
    rst_i = 1'b0;
    gain_req_i = 6'sd7;
    gain_req_valid_i = 1'b1;
    base = cyc;
    n = 0;
    while (gain_req_ready_o !== 1'b1 && n < 3000) begin step(); n++; end
    total++; if (cyc - (base + 1) != BASE_LAT || settled_o !== 1'b1) begin
      bad++; $display("FAIL mid_init_latency: got %0d settled=%b want %0d/1", cyc - (base + 1), settled_o, BASE_LAT);
    end
    total++; if (frames.size() != 1 || frames[0].data !== {8'h00, m_code(0)}) begin
      bad++; $display("FAIL mid_init_frame: frames=%0d want 1 frame %h", frames.size(), {8'h00, m_code(0)});
    end
    c = cyc;
    step();
    gain_req_valid_i = 1'b0;
    total++; if (gain_req_ready_o !== 1'b0) begin bad++; $display("FAIL mid_held_accept: ready=%b want 0", gain_req_ready_o); end
    n = 0;
    while (settled_o !== 1'b1 && n < 3000) begin step(); n++; end
    total++; if (int'(gain_dB_o) != 7 || cyc - (c + 1) != BASE_LAT + 1) begin
      bad++; $display("FAIL mid_held_result: gain=%0d latency=%0d want 7/%0d", gain_dB_o, cyc - (c + 1), BASE_LAT + 1);
    end
    total++; if (cs_fall_cnt - fall0 != 2 || frames.size() != 2) begin
      bad++; $display("FAIL mid_frame_count: cs falls=%0d frames=%0d want 2/2", cs_fall_cnt - fall0, frames.size());
    end
    if (frames.size() == 2) begin
      total++; if (frames[1].data !== {8'h00, m_code(7)}) begin bad++; $display("FAIL mid_held_frame: got %h want %h", frames[1].data, {8'h00, m_code(7)}); end
    end
    m_gain = 7;
    m_byp  = m_bypass(7);
    $display("mid-frame reset: init rewrite then held request gain=%0d", gain_dB_o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    test_reset();
    test_init_write();
    test_gain_up();
    test_gain_down();
    test_clamp();
    test_repeat();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
